// File: rtl/battle_if.sv
// Battle handshake between the game-state side (master) and the battle engine (slave).
interface battle_if;
  logic            is_battle;
  logic [7:0]      keycode;
  logic            frame_tick;
  logic [2:0][2:0] enemy_team;
  logic            end_battle;
  logic            result;
  logic [1:0]      my_cur;
  logic [2:0]      enemy_cur_id;
  logic            menu_sel;
  logic [5:0]      my_hp_cur;
  logic [5:0]      enemy_hp_cur;
  logic            busy;

  modport master (
    output is_battle, keycode, frame_tick, enemy_team,
    input  end_battle, result, my_cur, enemy_cur_id, menu_sel,
           my_hp_cur, enemy_hp_cur, busy
  );

  modport slave (
    input  is_battle, keycode, frame_tick, enemy_team,
    output end_battle, result, my_cur, enemy_cur_id, menu_sel,
           my_hp_cur, enemy_hp_cur, busy
  );
endinterface

// File: rtl/battle_engine.sv
// Turn-based battle controller: three player creatures against three enemies,
// keyboard-driven move selection with frame-timed attack animations.
module battle_engine #(
  parameter logic [5:0] MAX_HP      = 6'd20,
  parameter logic [5:0] DMG_A       = 6'd5,
  parameter logic [5:0] DMG_B       = 6'd8,
  parameter logic [5:0] ENEMY_DMG   = 6'd4,
  parameter logic [5:0] ANIM_FRAMES = 6'd30
) (
  input  logic     Clk,
  input  logic     Reset,
  battle_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, MENU, P_HIT, WAIT, E_CHECK, X_HIT, M_CHECK, DONE
  } state_t;

  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_ENTER = 8'h28;

  state_t          r_state, w_state_nxt;
  state_t          r_ret, w_ret_nxt;
  logic [2:0][5:0] r_my_hp, w_my_hp_nxt;
  logic [2:0][5:0] r_en_hp, w_en_hp_nxt;
  logic [1:0]      r_my_cur, w_my_cur_nxt;
  logic [1:0]      r_en_idx, w_en_idx_nxt;
  logic            r_menu_sel, w_sel_nxt;
  logic            r_result, w_result_nxt;
  logic [5:0]      r_timer, w_timer_nxt;
  logic [7:0]      r_keycode_q;
  logic            r_is_battle_q;
  logic            w_press;

  function automatic logic [5:0] sat_sub(input logic [5:0] hp, input logic [5:0] d);
    return (hp > d) ? hp - d : '0;
  endfunction

  assign w_press = (bus.keycode != 8'h00) && (bus.keycode != r_keycode_q);

  always_comb begin
    w_state_nxt  = r_state;
    w_ret_nxt    = r_ret;
    w_my_hp_nxt  = r_my_hp;
    w_en_hp_nxt  = r_en_hp;
    w_my_cur_nxt = r_my_cur;
    w_en_idx_nxt = r_en_idx;
    w_sel_nxt    = r_menu_sel;
    w_result_nxt = r_result;
    w_timer_nxt  = r_timer;
    // Abort takes priority over every state's own transition; all data holds.
    if (r_state != IDLE && !bus.is_battle) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.is_battle && !r_is_battle_q) begin
            w_my_hp_nxt  = {3{MAX_HP}};
            w_en_hp_nxt  = {3{MAX_HP}};
            w_my_cur_nxt = '0;
            w_en_idx_nxt = '0;
            w_sel_nxt    = 1'b0;
            w_result_nxt = 1'b0;
            w_state_nxt  = MENU;
          end
        end
        MENU: begin
          if (w_press) begin
            case (bus.keycode)
              KEY_A:     w_sel_nxt   = 1'b0;
              KEY_D:     w_sel_nxt   = 1'b1;
              KEY_ENTER: w_state_nxt = P_HIT;
              default:   ;
            endcase
          end
        end
        P_HIT: begin
          w_en_hp_nxt[r_en_idx] = sat_sub(r_en_hp[r_en_idx], r_menu_sel ? DMG_B : DMG_A);
          w_timer_nxt = ANIM_FRAMES;
          w_ret_nxt   = E_CHECK;
          w_state_nxt = WAIT;
        end
        WAIT: begin
          if (r_timer == '0) begin
            w_state_nxt = r_ret;
          end else if (bus.frame_tick) begin
            w_timer_nxt = r_timer - 6'd1;
          end
        end
        E_CHECK: begin
          if (r_en_hp[r_en_idx] == '0) begin
            if (r_en_idx == 2'd2) begin
              w_result_nxt = 1'b1;
              w_state_nxt  = DONE;
            end else begin
              w_en_idx_nxt = r_en_idx + 2'd1;
              w_state_nxt  = MENU;
            end
          end else begin
            w_state_nxt = X_HIT;
          end
        end
        X_HIT: begin
          w_my_hp_nxt[r_my_cur] = sat_sub(r_my_hp[r_my_cur], ENEMY_DMG);
          w_timer_nxt = ANIM_FRAMES;
          w_ret_nxt   = M_CHECK;
          w_state_nxt = WAIT;
        end
        M_CHECK: begin
          w_state_nxt = MENU;
          if (r_my_hp[r_my_cur] == '0) begin
            if (r_my_cur == 2'd2) begin
              w_result_nxt = 1'b0;
              w_state_nxt  = DONE;
            end else begin
              w_my_cur_nxt = r_my_cur + 2'd1;
            end
          end
        end
        DONE:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state       <= IDLE;
      r_ret         <= IDLE;
      r_my_hp       <= '0;
      r_en_hp       <= '0;
      r_my_cur      <= '0;
      r_en_idx      <= '0;
      r_menu_sel    <= 1'b0;
      r_result      <= 1'b0;
      r_timer       <= '0;
      r_keycode_q   <= '0;
      r_is_battle_q <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ret         <= w_ret_nxt;
      r_my_hp       <= w_my_hp_nxt;
      r_en_hp       <= w_en_hp_nxt;
      r_my_cur      <= w_my_cur_nxt;
      r_en_idx      <= w_en_idx_nxt;
      r_menu_sel    <= w_sel_nxt;
      r_result      <= w_result_nxt;
      r_timer       <= w_timer_nxt;
      r_keycode_q   <= bus.keycode;
      r_is_battle_q <= bus.is_battle;
    end
  end

  assign bus.end_battle   = (r_state == DONE);
  assign bus.busy         = (r_state == WAIT);
  assign bus.result       = r_result;
  assign bus.my_cur       = r_my_cur;
  assign bus.menu_sel     = r_menu_sel;
  assign bus.my_hp_cur    = r_my_hp[r_my_cur];
  assign bus.enemy_hp_cur = r_en_hp[r_en_idx];
  assign bus.enemy_cur_id = bus.enemy_team[r_en_idx];

endmodule
